cic_sequencer: RTL and testbench

- Control and sequencing wrapper for one CIC decimator instance: clears the filter, gates input samples into it, and discards the start-up transient outputs.
- Buffers decimated outputs in a small FIFO behind a valid/ready master port, and drains cleanly on stop.
- Sits between the sample source and downstream consumer; the CIC itself has no backpressure, so this block owns flow control.

---
 rtl/cic_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_cic_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cic_sequencer
// Purpose  : Clear/warm-up/run/drain sequencing and output FIFO for one CIC
//            decimator; owns all flow control around the filter.
// Revision : 1.0 - initial release
// ============================================================================
module cic_sequencer #(
  parameter int BITS    = 32,
  parameter int DEPTH   = 4,
  parameter int CLR_CYC = 2,
  parameter int LAT     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [7:0]      discard,
  input  logic [BITS-1:0] s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            cic_clr,
  output logic [BITS-1:0] cic_in,
  output logic            cic_valid,
  input  logic [BITS-1:0] cic_out,
  input  logic            cic_ready,
  output logic [BITS-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            busy,
  output logic            overflow,
  output logic [15:0]     out_count
);

  localparam int          c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          c_CW       = c_AW + 1;
  localparam logic [7:0]  c_CLR_LOAD = 8'(CLR_CYC - 1);
  localparam logic [7:0]  c_LAT_LOAD = 8'(LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WARMUP = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_clr;
  logic [7:0]        r_tmr;
  logic [7:0]        r_disc;
  logic              r_ovf;
  logic [15:0]       r_cnt_out;
  logic [BITS-1:0]   r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_capture;
  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_flush;

  assign w_full     = (r_count == c_CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  // During drain, strobes still belong to the warm-up transient until disc_cnt hits 0.
  assign w_capture  = (r_state == S_RUN) || ((r_state == S_DRAIN) && (r_disc == 8'd0));
  assign w_push_req = cic_ready && w_capture;
  assign w_pop      = m_valid && m_ready;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_flush    = (r_state == S_IDLE) && start;

  assign s_ready    = ((r_state == S_WARMUP) || (r_state == S_RUN)) && !w_full;
  assign cic_valid  = s_valid && s_ready;
  assign cic_in     = s_data;
  assign cic_clr    = r_clr;
  assign m_data     = r_mem[r_rd_ptr];
  assign m_valid    = !w_empty;
  assign busy       = (r_state != S_IDLE);
  assign overflow   = r_ovf;
  assign out_count  = r_cnt_out;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= cic_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_clr     <= 1'b1;
      r_tmr     <= '0;
      r_disc    <= '0;
      r_ovf     <= 1'b0;
      r_cnt_out <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end

      if (w_push) r_cnt_out <= r_cnt_out + 16'd1;
      if (w_drop) r_ovf     <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_clr <= 1'b0;
          if (start) begin
            r_state   <= S_CLEAR;
            r_clr     <= 1'b1;
            r_tmr     <= c_CLR_LOAD;
            r_disc    <= discard;
            r_ovf     <= 1'b0;
            r_cnt_out <= '0;
          end
        end
        S_CLEAR: begin
          if (stop) begin
            r_state <= S_DRAIN;
            r_clr   <= 1'b0;
            r_tmr   <= c_LAT_LOAD;
          end else if (r_tmr == 8'd0) begin
            r_clr   <= 1'b0;
            r_state <= (r_disc != 8'd0) ? S_WARMUP : S_RUN;
          end else begin
            r_tmr <= r_tmr - 8'd1;
          end
        end
        S_WARMUP: begin
          if (cic_ready) begin
            r_disc <= r_disc - 8'd1;
            if (r_disc == 8'd1) r_state <= S_RUN;
          end
          if (stop) begin
            r_state <= S_DRAIN;
            r_tmr   <= c_LAT_LOAD;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_DRAIN;
            r_tmr   <= c_LAT_LOAD;
          end
        end
        S_DRAIN: begin
          if (cic_ready && (r_disc != 8'd0)) r_disc <= r_disc - 8'd1;
          if (r_tmr != 8'd0) begin
            r_tmr <= r_tmr - 8'd1;
          end else if (w_empty) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_clr   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_sequencer
// Purpose  : Self-checking bench for cic_sequencer (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cic_sequencer;

  localparam int BITS    = 32;
  localparam int DEPTH   = 4;
  localparam int CLR_CYC = 2;
  localparam int LAT     = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, stop;
  logic [7:0]      discard;
  logic [BITS-1:0] s_data;
  logic            s_valid, s_ready;
  logic            cic_clr;
  logic [BITS-1:0] cic_in;
  logic            cic_valid;
  logic [BITS-1:0] cic_out;
  logic            cic_ready;
  logic [BITS-1:0] m_data;
  logic            m_valid, m_ready;
  logic            busy, overflow;
  logic [15:0]     out_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb_q[$];

  cic_sequencer #(.BITS(BITS), .DEPTH(DEPTH), .CLR_CYC(CLR_CYC), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .discard(discard),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cic_clr(cic_clr), .cic_in(cic_in), .cic_valid(cic_valid),
    .cic_out(cic_out), .cic_ready(cic_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .overflow(overflow), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted output word is compared to the oldest expected one.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got %0h expected none", m_data);
      end else begin
        chk("m_data", m_data, sb_q.pop_front());
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  disc;
    int          nstrobe;
    logic [15:0] exp_count;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic start_and_clear(input logic [7:0] d);
    int n;
    discard = d;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
    n = 0;
    while (cic_clr && n < 20) begin
      n++;
      cyc();
    end
    chk("clear_cycles", n, CLR_CYC);
  endtask

  task automatic stop_and_idle(input bit exact_lat);
    int n;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("s_ready_drain", s_ready, 1'b0);
    n = 0;
    while (busy && n < 200) begin
      n++;
      cyc();
    end
    chk("busy_after_drain", busy, 1'b0);
    if (exact_lat) chk("drain_cycles", n, LAT);
  endtask

  initial begin
    logic [31:0] v;
    int n;

    vecs[0] = '{disc: 8'd0, nstrobe: 8, exp_count: 16'd8, exp_ovf: 1'b0};
    vecs[1] = '{disc: 8'd3, nstrobe: 6, exp_count: 16'd3, exp_ovf: 1'b0};
    vecs[2] = '{disc: 8'd1, nstrobe: 1, exp_count: 16'd0, exp_ovf: 1'b0};
    vecs[3] = '{disc: 8'd5, nstrobe: 2, exp_count: 16'd0, exp_ovf: 1'b0};
    vecs[4] = '{disc: 8'd2, nstrobe: 5, exp_count: 16'd3, exp_ovf: 1'b0};

    rst = 1'b0; start = 1'b0; stop = 1'b0; discard = '0;
    s_data = 32'h1234_5678; s_valid = 1'b1;
    cic_out = '0; cic_ready = 1'b0; m_ready = 1'b1;

    // Reset state
    repeat (3) cyc();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_cic_valid", cic_valid, 1'b0);
    chk("rst_cic_clr", cic_clr, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_out_count", out_count, 16'd0);
    rst = 1'b1;
    cyc();
    chk("idle_cic_clr", cic_clr, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // Vector table: one start/strobe/stop session per row, m_ready held high
    for (int r = 0; r < 5; r++) begin
      start_and_clear(vecs[r].disc);
      chk("busy_active", busy, 1'b1);
      for (int i = 0; i < vecs[r].nstrobe; i++) begin
        repeat (7) cyc();
        v = 32'((r + 1) * 256 + i + 1);
        s_data    = 32'hA000_0000 + v;
        cic_out   = v;
        cic_ready = 1'b1;
        if (i >= int'(vecs[r].disc)) sb_q.push_back(v);
        if (i == 0) begin
          chk("s_ready_active", s_ready, 1'b1);
          chk("cic_valid", cic_valid, 1'b1);
          chk("cic_in", cic_in, 32'hA000_0000 + v);
        end
        cyc();
        cic_ready = 1'b0;
      end
      repeat (2) cyc();
      stop_and_idle(1'b1);
      chk("out_count", out_count, vecs[r].exp_count);
      chk("overflow", overflow, vecs[r].exp_ovf);
      chk("sb_empty", sb_q.size(), 0);
    end

    // Backpressure, full with simultaneous push+pop, then overflow
    m_ready = 1'b0;
    start_and_clear(8'd0);
    for (int i = 0; i < 4; i++) begin
      cic_out = 32'd100 + i;
      cic_ready = 1'b1;
      sb_q.push_back(32'd100 + i);
      cyc();
      cic_ready = 1'b0;
      if (i < 3) chk("s_ready_not_full", s_ready, 1'b1);
      cyc();
    end
    chk("s_ready_full", s_ready, 1'b0);
    chk("m_valid_full", m_valid, 1'b1);
    chk("m_data_head", m_data, 32'd100);
    cyc();
    chk("m_data_stable", m_data, 32'd100);
    m_ready = 1'b1;
    cic_out = 32'd104;
    cic_ready = 1'b1;
    sb_q.push_back(32'd104);
    cyc();
    m_ready = 1'b0;
    cic_ready = 1'b0;
    chk("no_ovf_push_pop", overflow, 1'b0);
    chk("still_full", s_ready, 1'b0);
    chk("head_after_pop", m_data, 32'd101);
    cyc();
    cic_out = 32'd105;
    cic_ready = 1'b1;
    cyc();
    cic_ready = 1'b0;
    chk("overflow_set", overflow, 1'b1);
    chk("count_after_drop", out_count, 16'd5);
    m_ready = 1'b1;
    repeat (6) cyc();
    chk("drained_m_valid", m_valid, 1'b0);
    chk("bp_sb_empty", sb_q.size(), 0);
    stop_and_idle(1'b1);
    chk("overflow_sticky", overflow, 1'b1);

    // Stop in CLEAR, with a start pulse during DRAIN that must be ignored
    start = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b1;
    chk("clear_clr_high", cic_clr, 1'b1);
    cyc();
    stop = 1'b0;
    chk("stopclr_clr_low", cic_clr, 1'b0);
    chk("stopclr_busy", busy, 1'b1);
    chk("stopclr_s_ready", s_ready, 1'b0);
    n = 0;
    while (busy && n < 50) begin
      n++;
      start = (n == 2);
      cyc();
    end
    start = 1'b0;
    chk("stopclr_drain_cycles", n, LAT);
    repeat (2) cyc();
    chk("start_in_drain_ignored", busy, 1'b0);
    chk("stopclr_out_count", out_count, 16'd0);
    chk("stopclr_overflow", overflow, 1'b0);

    // Asynchronous reset mid-RUN with two words held in the FIFO
    m_ready = 1'b0;
    start_and_clear(8'd0);
    for (int i = 0; i < 2; i++) begin
      cic_out = 32'd200 + i;
      cic_ready = 1'b1;
      sb_q.push_back(32'd200 + i);
      cyc();
      cic_ready = 1'b0;
    end
    chk("pre_rst_m_valid", m_valid, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_cic_clr", cic_clr, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_s_ready", s_ready, 1'b0);
    sb_q.delete();
    cyc();
    rst = 1'b1;
    cyc();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_overflow", overflow, 1'b0);
    chk("post_rst_cic_clr", cic_clr, 1'b0);
    chk("post_rst_out_count", out_count, 16'd0);
    chk("post_rst_m_valid", m_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
